fxdiv: RTL and testbench

//  Sequential fixed-point divider; inverse of the combinational mul/muls multipliers.

---
 rtl/fxp_pkg.sv | 9 +
 rtl/fxdiv_step.sv | 18 +
 rtl/fxdiv.sv | 125 ++++++++++++
 tb/tb_fxdiv.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fxp_pkg.sv
// Shared fixed-point defaults and types for the fxp arithmetic blocks.
package fxp_pkg;
  localparam int FXP_TOTAL_BITS      = 16;
  localparam int FXP_FRACTIONAL_BITS = 8;

  typedef logic [FXP_TOTAL_BITS-1:0] fxp_t;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} fxdiv_state_t;
endpackage

// File: rtl/fxdiv_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module fxdiv_step #(
  parameter int W = 16
) (
  input  logic [W:0]   rem_in,
  input  logic         dbit,
  input  logic [W-1:0] divisor,
  output logic [W:0]   rem_out,
  output logic         q_bit
);
  logic [W+1:0] sh, diff;

  assign sh      = {rem_in, dbit};
  // One extra bit so the borrow shows up as the sign of the difference.
  assign diff    = sh - {2'b00, divisor};
  assign q_bit   = ~diff[W+1];
  assign rem_out = q_bit ? diff[W:0] : sh[W:0];
endmodule

// File: rtl/fxdiv.sv
// Sequential fixed-point divider: out = (in1 << FRAC) / in2, one quotient bit per clock.
module fxdiv
  import fxp_pkg::*;
#(
  parameter int TOTAL_BITS      = FXP_TOTAL_BITS,
  parameter int FRACTIONAL_BITS = FXP_FRACTIONAL_BITS,
  parameter bit SIGNED          = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [TOTAL_BITS-1:0] in1,
  input  logic [TOTAL_BITS-1:0] in2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TOTAL_BITS-1:0] out,
  output logic                  overflow,
  output logic                  div_by_zero
);
  localparam int N  = TOTAL_BITS + FRACTIONAL_BITS;
  localparam int CW = $clog2(N);
  localparam logic [TOTAL_BITS-1:0] ONES    = '1;
  localparam logic [TOTAL_BITS-1:0] POS_MAX = {1'b0, {(TOTAL_BITS-1){1'b1}}};
  localparam logic [TOTAL_BITS-1:0] NEG_MAX = {1'b1, {(TOTAL_BITS-1){1'b0}}};

  fxdiv_state_t          state;
  logic [CW-1:0]         cnt;
  logic [TOTAL_BITS:0]   rem, rem_nxt;
  logic [N-1:0]          dvd, q_fin, lim;
  logic [N-2:0]          q;
  logic [TOTAL_BITS-1:0] dvs, a1, a2, res;
  logic                  neg, sgn1, zdiv, q_bit, res_ovf;

  // |x| in TOTAL_BITS unsigned; the most negative value maps onto itself.
  assign a1 = (SIGNED && in1[TOTAL_BITS-1]) ? -in1 : in1;
  assign a2 = (SIGNED && in2[TOTAL_BITS-1]) ? -in2 : in2;

  fxdiv_step #(.W(TOTAL_BITS)) u_step (
    .rem_in  (rem),
    .dbit    (dvd[N-1]),
    .divisor (dvs),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  assign q_fin = {q, q_bit};
  assign lim   = {{FRACTIONAL_BITS{1'b0}}, (neg ? NEG_MAX : POS_MAX)};

  always_comb begin
    res     = q_fin[TOTAL_BITS-1:0];
    res_ovf = 1'b0;
    if (!SIGNED) begin
      if (|q_fin[N-1:TOTAL_BITS]) begin
        res     = ONES;
        res_ovf = 1'b1;
      end
    end else if (q_fin > lim) begin
      res     = neg ? NEG_MAX : POS_MAX;
      res_ovf = 1'b1;
    end else if (neg) begin
      res = -q_fin[TOTAL_BITS-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out         <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      rem         <= '0;
      dvd         <= '0;
      q           <= '0;
      dvs         <= '0;
      neg         <= 1'b0;
      sgn1        <= 1'b0;
      zdiv        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          state    <= BUSY;
          in_ready <= 1'b0;
          cnt      <= CW'(N-1);
          rem      <= '0;
          q        <= '0;
          dvd      <= {a1, {FRACTIONAL_BITS{1'b0}}};
          dvs      <= a2;
          neg      <= SIGNED && (in1[TOTAL_BITS-1] ^ in2[TOTAL_BITS-1]);
          sgn1     <= SIGNED && in1[TOTAL_BITS-1];
          zdiv     <= (in2 == '0);
        end
        BUSY: begin
          rem <= rem_nxt;
          dvd <= {dvd[N-2:0], 1'b0};
          q   <= q_fin[N-2:0];
          cnt <= cnt - CW'(1);
          // Last step: the final quotient bit is still combinational here.
          if (cnt == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            if (zdiv) begin
              out         <= sgn1 ? NEG_MAX : (SIGNED ? POS_MAX : ONES);
              overflow    <= 1'b0;
              div_by_zero <= 1'b1;
            end else begin
              out         <= res;
              overflow    <= res_ovf;
              div_by_zero <= 1'b0;
            end
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fxdiv.sv
// Bench for fxdiv: unsigned and signed U/S(16,8) instances, vector table plus handshake/reset sequences.
module tb_fxdiv;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        in_valid[2], in_ready[2], out_valid[2], out_ready[2];
  logic        overflow[2], div_by_zero[2];
  logic [15:0] in1[2], in2[2], out[2];

  fxdiv #(.TOTAL_BITS(16), .FRACTIONAL_BITS(8), .SIGNED(1'b0)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in1(in1[0]), .in2(in2[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out(out[0]), .overflow(overflow[0]), .div_by_zero(div_by_zero[0]));

  fxdiv #(.TOTAL_BITS(16), .FRACTIONAL_BITS(8), .SIGNED(1'b1)) s_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in1(in1[1]), .in2(in2[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out(out[1]), .overflow(overflow[1]), .div_by_zero(div_by_zero[1]));

  typedef struct { logic [15:0] o; logic ovf; logic dz; } exp_t;
  typedef struct { int d; logic [15:0] a; logic [15:0] b; logic [15:0] o; logic ovf; logic dz; } vec_t;

  exp_t sb[$];
  vec_t vt[$];
  int checks = 0;
  int errors = 0;

  function automatic exp_t mk(logic [15:0] o, logic ovf, logic dz);
    exp_t e;
    e.o = o; e.ovf = ovf; e.dz = dz;
    return e;
  endfunction

  function automatic vec_t mv(int d, logic [15:0] a, logic [15:0] b, logic [15:0] o, logic ovf, logic dz);
    vec_t v;
    v.d = d; v.a = a; v.b = b; v.o = o; v.ovf = ovf; v.dz = dz;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_idle(int d, string name);
    chk({name, " in_ready"},  32'(in_ready[d]), 32'd1);
    chk({name, " out_valid"}, 32'(out_valid[d]), 32'd0);
    chk({name, " out"},       32'(out[d]), 32'd0);
    chk({name, " overflow"},  32'(overflow[d]), 32'd0);
    chk({name, " div_by_zero"}, 32'(div_by_zero[d]), 32'd0);
  endtask

  // Called at a negedge; returns 1 ns after the accept edge.
  task automatic send(int d, logic [15:0] a, logic [15:0] b, exp_t e);
    bit ok = 0;
    in1[d] = a; in2[d] = b; in_valid[d] = 1'b1;
    sb.push_back(e);
    for (int i = 0; i < 200; i++) begin
      if (in_ready[d]) begin ok = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL accept timeout: got in_ready 0 expected 1"); end
    @(posedge clk);
    #1 in_valid[d] = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid, compares, then handshakes.
  task automatic collect(int d, int hold);
    int n = 0;
    bit seen = 0;
    exp_t e;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (out_valid[d]) begin seen = 1; break; end
    end
    chk("out_valid seen", 32'(seen), 32'd1);
    chk("latency", 32'(n), 32'd24);
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard empty: got 0 entries expected 1");
      e = mk(16'h0, 1'b0, 1'b0);
    end else e = sb.pop_front();
    chk("out", 32'(out[d]), 32'(e.o));
    chk("overflow", 32'(overflow[d]), 32'(e.ovf));
    chk("div_by_zero", 32'(div_by_zero[d]), 32'(e.dz));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold out_valid", 32'(out_valid[d]), 32'd1);
      chk("hold in_ready", 32'(in_ready[d]), 32'd0);
      chk("hold out", 32'(out[d]), 32'(e.o));
    end
    out_ready[d] = 1'b1;
    @(posedge clk);
    #1 out_ready[d] = 1'b0;
    @(negedge clk);
    chk("post-hs out_valid", 32'(out_valid[d]), 32'd0);
    chk("post-hs out held", 32'(out[d]), 32'(e.o));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t bv[3];
    int idx, nh, last_acc, last_hs;
    bit ir, ov, prev_ov;
    logic [15:0] o;
    logic f, z;
    exp_t e;

    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; out_ready[d] = 1'b0; in1[d] = '0; in2[d] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    chk_idle(0, "reset u");
    chk_idle(1, "reset s");

    vt.push_back(mv(0, 16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0));
    vt.push_back(mv(0, 16'h0100, 16'h0300, 16'h0055, 1'b0, 1'b0));
    vt.push_back(mv(0, 16'h8000, 16'h0080, 16'hFFFF, 1'b1, 1'b0));
    vt.push_back(mv(0, 16'h1234, 16'h0000, 16'hFFFF, 1'b0, 1'b1));
    vt.push_back(mv(0, 16'h0000, 16'h0500, 16'h0000, 1'b0, 1'b0));
    vt.push_back(mv(0, 16'hFFFF, 16'hFFFF, 16'h0100, 1'b0, 1'b0));
    vt.push_back(mv(1, 16'hFD00, 16'h0200, 16'hFE80, 1'b0, 1'b0));
    vt.push_back(mv(1, 16'h8000, 16'hFF00, 16'h7FFF, 1'b1, 1'b0));
    vt.push_back(mv(1, 16'hFF00, 16'h0000, 16'h8000, 1'b0, 1'b1));
    vt.push_back(mv(1, 16'h0100, 16'h0000, 16'h7FFF, 1'b0, 1'b1));
    vt.push_back(mv(1, 16'h8000, 16'h0100, 16'h8000, 1'b0, 1'b0));
    vt.push_back(mv(1, 16'h0100, 16'hFF00, 16'hFF00, 1'b0, 1'b0));
    vt.push_back(mv(1, 16'h0000, 16'hFF00, 16'h0000, 1'b0, 1'b0));
    vt.push_back(mv(1, 16'hFF00, 16'hFD00, 16'h0055, 1'b0, 1'b0));

    foreach (vt[i]) begin
      send(vt[i].d, vt[i].a, vt[i].b, mk(vt[i].o, vt[i].ovf, vt[i].dz));
      collect(vt[i].d, 0);
    end

    // Consumer stalls for 10 cycles with the result pending.
    send(0, 16'h0100, 16'h0300, mk(16'h0055, 1'b0, 1'b0));
    collect(0, 10);

    // Back-to-back with in_valid and out_ready held high.
    bv[0] = mv(0, 16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0);
    bv[1] = mv(0, 16'h0100, 16'h0300, 16'h0055, 1'b0, 1'b0);
    bv[2] = mv(0, 16'h1234, 16'h0000, 16'hFFFF, 1'b0, 1'b1);
    idx = 0; nh = 0; last_acc = -100; last_hs = -100; prev_ov = 0;
    in1[0] = bv[0].a; in2[0] = bv[0].b; in_valid[0] = 1'b1; out_ready[0] = 1'b1;
    for (int ed = 1; ed <= 300 && nh < 3; ed++) begin
      ir = in_ready[0]; ov = out_valid[0];
      o = out[0]; f = overflow[0]; z = div_by_zero[0];
      if (ov && !prev_ov) chk("b2b latency", 32'(ed - 1 - last_acc), 32'd24);
      prev_ov = ov;
      @(posedge clk);
      if (ov) begin
        nh++;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL b2b scoreboard empty: got 0 entries expected 1");
        end else begin
          e = sb.pop_front();
          chk("b2b out", 32'(o), 32'(e.o));
          chk("b2b overflow", 32'(f), 32'(e.ovf));
          chk("b2b div_by_zero", 32'(z), 32'(e.dz));
        end
      end
      if (ir && idx < 3) begin
        if (idx > 0) chk("b2b accept after hs", 32'(ed), 32'(last_hs + 1));
        last_acc = ed;
        sb.push_back(mk(bv[idx].o, bv[idx].ovf, bv[idx].dz));
        idx++;
        #1;
        if (idx < 3) begin in1[0] = bv[idx].a; in2[0] = bv[idx].b; end
        else in_valid[0] = 1'b0;
      end
      if (ov) last_hs = ed;
      @(negedge clk);
    end
    chk("b2b handshakes", 32'(nh), 32'd3);
    in_valid[0] = 1'b0; out_ready[0] = 1'b0;
    @(negedge clk);

    // Reset lands on the 7th iteration of a division.
    send(0, 16'h1234, 16'h0100, mk(16'h1234, 1'b0, 1'b0));
    repeat (6) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_idle(0, "mid reset");
    reset = 1'b0;
    sb.delete();
    begin
      bit stray = 0;
      repeat (30) begin
        @(negedge clk);
        if (out_valid[0]) stray = 1;
      end
      chk("no result after reset", 32'(stray), 32'd0);
    end
    send(0, 16'h0300, 16'h0200, mk(16'h0180, 1'b0, 1'b0));
    collect(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
